// File: rtl/fsm_add_subt_ctrl.sv
// Sequencer for the iterative FP add/subtract datapath: load, exponent compare,
// align, add/sub, normalize, round, then hold the result until acknowledged.
module fsm_add_subt_ctrl #(
  parameter int MAX_ALIGN = 26,
  parameter int MAX_NORM  = 26,
  parameter int EW        = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic          ack_i,
  input  logic [EW-1:0] exp_diff_i,
  input  logic          zero_i,
  input  logic          carry_i,
  input  logic          msb_i,
  input  logic          exp_max_i,
  input  logic          exp_zero_i,
  input  logic          round_ovf_i,
  output logic          ready_o,
  output logic          load_ops_o,
  output logic          load_diff_o,
  output logic          shift_r_en_o,
  output logic          shift_l_en_o,
  output logic          exp_inc_o,
  output logic          exp_dec_o,
  output logic          add_en_o,
  output logic          round_en_o,
  output logic          done_o,
  output logic          zero_o,
  output logic          overflow_o,
  output logic          underflow_o,
  output logic [2:0]    state_o
);
  localparam int NW = $clog2(MAX_NORM + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_LOAD = 3'd1, S_EXP_CMP = 3'd2, S_ALIGN = 3'd3,
    S_ADDSUB = 3'd4, S_NORM = 3'd5, S_ROUND = 3'd6, S_DONE = 3'd7
  } state_t;

  state_t        state_q, state_d;
  logic [EW-1:0] acnt_q, acnt_d;
  logic [NW-1:0] ncnt_q, ncnt_d;
  logic          zero_q, zero_d, ovf_q, ovf_d, unf_q, unf_d;
  logic          rnd_pass_q, rnd_pass_d;

  // Prioritised NORM decision, shared by next-state and Mealy output logic
  logic n_zero, n_ovf, n_carry, n_msb, n_unf, n_shift;
  always_comb begin
    n_zero  = zero_i;
    n_ovf   = !zero_i && carry_i && exp_max_i;
    n_carry = !zero_i && carry_i && !exp_max_i;
    n_msb   = !zero_i && !carry_i && msb_i;
    n_unf   = !zero_i && !carry_i && !msb_i &&
              (exp_zero_i || (ncnt_q == NW'(MAX_NORM)));
    n_shift = !(n_zero || n_ovf || n_carry || n_msb || n_unf);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acnt_q     <= '0;
      ncnt_q     <= '0;
      zero_q     <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      rnd_pass_q <= 1'b0;
    end else begin
      acnt_q     <= acnt_d;
      ncnt_q     <= ncnt_d;
      zero_q     <= zero_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      rnd_pass_q <= rnd_pass_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    acnt_d     = acnt_q;
    ncnt_d     = ncnt_q;
    zero_d     = zero_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    rnd_pass_d = rnd_pass_q;
    case (state_q)
      S_IDLE:    if (start_i) state_d = S_LOAD;
      S_LOAD: begin
        zero_d     = 1'b0;
        ovf_d      = 1'b0;
        unf_d      = 1'b0;
        rnd_pass_d = 1'b0;
        state_d    = S_EXP_CMP;
      end
      S_EXP_CMP: begin
        if (exp_diff_i == '0) begin
          state_d = S_ADDSUB;
        end else begin
          acnt_d  = (exp_diff_i > EW'(MAX_ALIGN)) ? EW'(MAX_ALIGN) : exp_diff_i;
          state_d = S_ALIGN;
        end
      end
      S_ALIGN: begin
        acnt_d = acnt_q - EW'(1);
        if (acnt_q == EW'(1)) state_d = S_ADDSUB;
      end
      S_ADDSUB: begin
        ncnt_d  = '0;
        state_d = S_NORM;
      end
      S_NORM: begin
        if (n_zero) begin
          zero_d  = 1'b1;
          state_d = S_DONE;
        end else if (n_ovf) begin
          ovf_d   = 1'b1;
          state_d = S_DONE;
        end else if (n_carry || n_msb) begin
          state_d = S_ROUND;
        end else if (n_unf) begin
          unf_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          ncnt_d  = ncnt_q + NW'(1);
        end
      end
      S_ROUND: begin
        // Only one re-normalize pass; a second rounding carry is dropped
        if (round_ovf_i && !rnd_pass_q) begin
          rnd_pass_d = 1'b1;
          state_d    = S_NORM;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:    if (ack_i) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready_o      = (state_q == S_IDLE);
    load_ops_o   = (state_q == S_LOAD);
    load_diff_o  = (state_q == S_EXP_CMP);
    add_en_o     = (state_q == S_ADDSUB);
    round_en_o   = (state_q == S_ROUND);
    done_o       = (state_q == S_DONE);
    shift_r_en_o = (state_q == S_ALIGN) || ((state_q == S_NORM) && n_carry);
    exp_inc_o    = (state_q == S_NORM) && n_carry;
    shift_l_en_o = (state_q == S_NORM) && n_shift;
    exp_dec_o    = (state_q == S_NORM) && n_shift;
    zero_o       = zero_q;
    overflow_o   = ovf_q;
    underflow_o  = unf_q;
    state_o      = state_q;
  end

endmodule

// File: tb/tb_fsm_add_subt_ctrl.sv
// Randomized bench with a scoreboard: per-operation pulse counts, flags and latency
// predicted from the sequencing rules and checked when done_o appears.
module tb_fsm_add_subt_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_i, ack_i;
  logic [7:0] exp_diff_i;
  logic       zero_i, carry_i, msb_i, exp_max_i, exp_zero_i, round_ovf_i;
  logic       ready_o, load_ops_o, load_diff_o, shift_r_en_o, shift_l_en_o;
  logic       exp_inc_o, exp_dec_o, add_en_o, round_en_o, done_o;
  logic       zero_o, overflow_o, underflow_o;
  logic [2:0] state_o;

  fsm_add_subt_ctrl #(.MAX_ALIGN(26), .MAX_NORM(26), .EW(8)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .ack_i(ack_i),
    .exp_diff_i(exp_diff_i), .zero_i(zero_i), .carry_i(carry_i), .msb_i(msb_i),
    .exp_max_i(exp_max_i), .exp_zero_i(exp_zero_i), .round_ovf_i(round_ovf_i),
    .ready_o(ready_o), .load_ops_o(load_ops_o), .load_diff_o(load_diff_o),
    .shift_r_en_o(shift_r_en_o), .shift_l_en_o(shift_l_en_o),
    .exp_inc_o(exp_inc_o), .exp_dec_o(exp_dec_o), .add_en_o(add_en_o),
    .round_en_o(round_en_o), .done_o(done_o), .zero_o(zero_o),
    .overflow_o(overflow_o), .underflow_o(underflow_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int diff; bit z; bit c; bit m; bit ro; int lsh_need; int dec_to_zero;
  } op_t;
  typedef struct {
    int rsh; int lsh; int inc; int dec; int add; int rnd;
    bit z; bit o; bit u; int lat;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0, failures = 0;
  int   cyc = 0, start_cyc = 0;
  int   cur_l = 0, cur_e = 0;
  int   lcnt = 0, dcnt = 0;
  int   c_rsh, c_lsh, c_inc, c_dec, c_add, c_rnd;
  bit   done_seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: outcome of one operation from the sequencing rules
  function automatic exp_t model(input op_t o);
    exp_t e;
    int   d, lim;
    e = '{default: 0};
    d = (o.diff > 26) ? 26 : o.diff;
    e.rsh = d;
    e.add = 1;
    if (o.z) begin
      e.z = 1; e.lat = 5 + d;
    end else if (o.c && o.m) begin
      e.o = 1; e.lat = 5 + d;
    end else if (o.c) begin
      e.rsh = d + (o.ro ? 2 : 1);
      e.inc = o.ro ? 2 : 1;
      e.rnd = o.ro ? 2 : 1;
      e.lat = 6 + d + (o.ro ? 2 : 0);
    end else begin
      lim = (o.dec_to_zero < 26) ? o.dec_to_zero : 26;
      if (o.lsh_need <= lim) begin
        e.lsh = o.lsh_need; e.dec = o.lsh_need;
        e.rnd = o.ro ? 2 : 1;
        e.lat = 6 + d + o.lsh_need + (o.ro ? 2 : 0);
      end else begin
        e.lsh = lim; e.dec = lim; e.u = 1;
        e.lat = 5 + d + lim;
      end
    end
    return e;
  endfunction

  // Datapath stand-in: msb/exp_zero follow the number of shifts/decrements seen
  initial forever begin
    @(posedge clk);
    #1;
    msb_i      = (lcnt >= cur_l);
    exp_zero_i = (dcnt >= cur_e);
  end

  // Monitor: count enable pulses per operation, score on done_o
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst_n) begin
      if (load_ops_o) begin
        lcnt = 0; dcnt = 0;
        c_rsh = 0; c_lsh = 0; c_inc = 0; c_dec = 0; c_add = 0; c_rnd = 0;
      end
      if (shift_r_en_o) c_rsh++;
      if (shift_l_en_o) begin c_lsh++; lcnt++; end
      if (exp_inc_o)    c_inc++;
      if (exp_dec_o)    begin c_dec++; dcnt++; end
      if (add_en_o)     c_add++;
      if (round_en_o)   c_rnd++;
      if (done_o && !done_seen) begin
        done_seen = 1'b1;
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb_q.pop_front();
          chk("latency",   cyc - start_cyc, e.lat);
          chk("shift_r",   c_rsh, e.rsh);
          chk("shift_l",   c_lsh, e.lsh);
          chk("exp_inc",   c_inc, e.inc);
          chk("exp_dec",   c_dec, e.dec);
          chk("add_en",    c_add, e.add);
          chk("round_en",  c_rnd, e.rnd);
          chk("zero_o",    int'(zero_o), int'(e.z));
          chk("overflow",  int'(overflow_o), int'(e.o));
          chk("underflow", int'(underflow_o), int'(e.u));
          chk("done_state", int'(state_o), 7);
          chk("done_ready", int'(ready_o), 0);
          chk("done_enables", int'({load_ops_o, load_diff_o, shift_r_en_o,
              shift_l_en_o, exp_inc_o, exp_dec_o, add_en_o, round_en_o}), 0);
        end
      end
      if (!done_o) done_seen = 1'b0;
    end
  end

  task automatic wait_ready();
    bit got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ready_o) begin got = 1'b1; break; end
    end
    if (!got) chk("ready_timeout", 0, 1);
  endtask

  task automatic issue(input op_t o);
    @(posedge clk);
    #1;
    exp_diff_i  = 8'(o.diff);
    zero_i      = o.z;
    carry_i     = o.c;
    exp_max_i   = o.m;
    round_ovf_i = o.ro;
    cur_l       = o.lsh_need;
    cur_e       = o.dec_to_zero;
    start_i     = 1'b1;
    start_cyc   = cyc;
  endtask

  task automatic run_op(input op_t o, input bit start_with_ack);
    bit got = 1'b0;
    wait_ready();
    issue(o);
    sb_q.push_back(model(o));
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      start_i = 1'($urandom_range(0, 1));
      ack_i   = (i < 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      if (done_o) begin got = 1'b1; break; end
    end
    chk("done_seen", int'(got), 1);
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk);
      #1;
      start_i = 1'($urandom_range(0, 1));
    end
    @(posedge clk);
    #1;
    ack_i   = 1'b1;
    start_i = start_with_ack;
    @(posedge clk);
    #1;
    ack_i   = 1'b0;
    start_i = 1'b0;
    if (start_with_ack) begin
      @(negedge clk);
      chk("ack_wins_state", int'(state_o), 0);
      @(negedge clk);
      chk("ack_wins_no_load", int'(state_o), 0);
    end
  endtask

  op_t dir[$];

  initial begin
    op_t o;
    rst_n = 1'b0;
    start_i = 1'b0; ack_i = 1'b0; exp_diff_i = '0;
    zero_i = 1'b0; carry_i = 1'b0; msb_i = 1'b0;
    exp_max_i = 1'b0; exp_zero_i = 1'b0; round_ovf_i = 1'b0;
    #1;
    chk("rst_ready", int'(ready_o), 1);
    chk("rst_state", int'(state_o), 0);
    chk("rst_outputs", int'({load_ops_o, load_diff_o, shift_r_en_o, shift_l_en_o,
        exp_inc_o, exp_dec_o, add_en_o, round_en_o, done_o,
        zero_o, overflow_o, underflow_o}), 0);
    #12 rst_n = 1'b1;

    dir.push_back('{3,  0, 0, 0, 0, 0,  99});
    dir.push_back('{40, 0, 0, 0, 0, 0,  99});
    dir.push_back('{0,  0, 0, 0, 0, 4,  99});
    dir.push_back('{5,  0, 1, 1, 0, 0,  99});
    dir.push_back('{2,  0, 0, 0, 1, 1,  99});
    dir.push_back('{4,  0, 1, 0, 1, 0,  99});
    dir.push_back('{0,  0, 0, 0, 0, 40, 99});
    dir.push_back('{1,  0, 0, 0, 0, 10, 3});
    dir.push_back('{26, 0, 0, 0, 0, 26, 26});
    foreach (dir[i]) run_op(dir[i], 1'b0);
    run_op('{1, 1, 0, 0, 0, 0, 99}, 1'b1);

    for (int n = 0; n < 40; n++) begin
      o.diff        = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 60))
                                                  : int'($urandom_range(0, 8));
      o.z           = ($urandom_range(0, 7) == 0);
      o.c           = ($urandom_range(0, 3) == 0);
      o.m           = ($urandom_range(0, 1) == 0);
      o.ro          = ($urandom_range(0, 2) == 0);
      o.lsh_need    = int'($urandom_range(0, 30));
      o.dec_to_zero = int'($urandom_range(0, 35));
      run_op(o, 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of an alignment run
    begin
      bit got = 1'b0;
      wait_ready();
      issue('{20, 0, 0, 0, 0, 0, 99});
      @(posedge clk);
      #1 start_i = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (state_o == 3'd3) begin got = 1'b1; break; end
      end
      chk("reached_align", int'(got), 1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_state", int'(state_o), 0);
      chk("midrst_ready", int'(ready_o), 1);
      chk("midrst_shift_r", int'(shift_r_en_o), 0);
      @(negedge clk);
      rst_n = 1'b1;
    end
    run_op('{3, 0, 0, 0, 0, 2, 99}, 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
